// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with step enable, runtime load, lock-up recovery
// and measurement of the number of steps taken to return to the start value.
module lfsr_gen #(
    parameter int unsigned           WIDTH = 9,
    parameter logic [WIDTH-1:0]      TAPS  = 9'h110,
    parameter bit                    XNOR  = 1'b0,
    parameter logic [WIDTH-1:0]      SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             fb_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] period_len_o,
    output logic             lockup_o
);

    // XOR feedback sticks at all-zeros, XNOR feedback sticks at all-ones.
    localparam logic [WIDTH-1:0] LOCK_STATE = {WIDTH{XNOR}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic             fb;
    logic [WIDTH-1:0] step_q;

    assign fb     = (^(q_q & TAPS)) ^ XNOR;
    assign step_q = {q_q[WIDTH-2:0], fb};

    always_comb begin
        q_d      = q_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load_i) begin
            q_d     = load_val_i;
            start_d = load_val_i;
            cnt_d   = '0;
        end else if (en_i) begin
            if (q_q == LOCK_STATE) begin
                q_d      = SEED;
                start_d  = SEED;
                cnt_d    = '0;
                lockup_d = 1'b1;
            end else begin
                q_d = step_q;
                // cnt cannot overflow: the longest cycle is 2^WIDTH-1 steps.
                if (step_q == start_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_q + 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q      <= SEED;
            start_q  <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign q_o          = q_q;
    assign fb_o         = fb;
    assign wrap_o       = wrap_q;
    assign period_len_o = period_q;
    assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: default XOR instance checked against a step-level model,
// plus an XNOR/SEED=0 instance exercised with directed lock-up steps.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, load;
    logic [8:0] load_val;
    logic [8:0] q, period_len;
    logic       fb, wrap, lockup;

    logic       rst1, en1, load1;
    logic [8:0] load_val1;
    logic [8:0] q1, period_len1;
    logic       fb1, wrap1, lockup1;

    lfsr_gen u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .load_val_i(load_val),
        .q_o(q), .fb_o(fb), .wrap_o(wrap), .period_len_o(period_len), .lockup_o(lockup)
    );

    lfsr_gen #(.WIDTH(9), .TAPS(9'h110), .XNOR(1'b1), .SEED(9'h000)) u_xnor (
        .clk_i(clk), .rst_i(rst1), .en_i(en1), .load_i(load1), .load_val_i(load_val1),
        .q_o(q1), .fb_o(fb1), .wrap_o(wrap1), .period_len_o(period_len1), .lockup_o(lockup1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (XOR, SEED=1, taps at bits 8 and 4).
    int unsigned m_q, m_start, m_cnt, m_period;
    bit m_wrap, m_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_fb(input int unsigned s);
        int unsigned b8, b4;
        b8 = (s / 256) % 2;
        b4 = (s / 16) % 2;
        return (b8 + b4) % 2;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit l, input logic [8:0] v);
        @(negedge clk);
        rst = r; en = e; load = l; load_val = v;
        @(posedge clk);
        m_wrap = 1'b0;
        m_lock = 1'b0;
        if (r) begin
            m_q = 1; m_start = 1; m_cnt = 0; m_period = 0;
        end else if (l) begin
            m_q = v; m_start = v; m_cnt = 0;
        end else if (e) begin
            if (m_q == 0) begin
                m_q = 1; m_start = 1; m_cnt = 0; m_lock = 1'b1;
            end else begin
                m_q = (m_q * 2 + ref_fb(m_q)) % 512;
                m_cnt++;
                if (m_q == m_start) begin
                    m_wrap = 1'b1; m_period = m_cnt; m_cnt = 0;
                end
            end
        end
        #1;
        chk("q", q, m_q);
        chk("fb", fb, ref_fb(m_q));
        chk("wrap", wrap, m_wrap);
        chk("lockup", lockup, m_lock);
        chk("period_len", period_len, m_period);
    endtask

    task automatic run_period(input string tag, input logic [8:0] exp_q, input int nsteps);
        int nwrap, first_at;
        nwrap = 0; first_at = -1;
        for (int i = 1; i <= nsteps; i++) begin
            cyc(0, 1, 0, 9'h0);
            if (wrap === 1'b1) begin
                nwrap++;
                if (first_at < 0) first_at = i;
                chk({tag, "_wrap_q"}, q, exp_q);
                chk({tag, "_wrap_len"}, period_len, 511);
            end
        end
        chk({tag, "_wrap_count"}, nwrap, nsteps / 511);
        chk({tag, "_first_wrap"}, first_at, 511);
    endtask

    initial begin
        logic [8:0] exp5 [5];
        logic [8:0] held;
        exp5 = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        rst1 = 1'b1; en1 = 1'b0; load1 = 1'b0; load_val1 = '0;

        // Reset then first five steps
        cyc(1, 0, 0, 9'h0);
        chk("reset_q", q, 9'h001);
        chk("reset_len", period_len, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 9'h0);
            chk("first_steps_q", q, exp5[i]);
        end

        // Full periods from reset, then from a loaded value
        cyc(1, 0, 0, 9'h0);
        run_period("seed", 9'h001, 1022);
        cyc(0, 0, 1, 9'h0AB);
        for (int i = 0; i < 100; i++) cyc(0, 1, 0, 9'h0);
        cyc(0, 0, 1, 9'h0AB);
        run_period("load", 9'h0AB, 511);

        // Lock-up recovery
        cyc(0, 0, 1, 9'h000);
        chk("lock_loaded_q", q, 9'h000);
        chk("lock_loaded_pulse", lockup, 1'b0);
        cyc(0, 1, 0, 9'h0);
        chk("lock_q", q, 9'h001);
        chk("lock_pulse", lockup, 1'b1);
        chk("lock_nowrap", wrap, 1'b0);
        cyc(0, 1, 0, 9'h0);
        chk("lock_pulse_once", lockup, 1'b0);

        // en toggled 1,0,0,1
        cyc(0, 1, 0, 9'h0);
        held = q;
        cyc(0, 0, 0, 9'h0);
        chk("hold1_q", q, held);
        cyc(0, 0, 0, 9'h0);
        chk("hold2_q", q, held);
        cyc(0, 1, 0, 9'h0);
        chk("resume_changed", (q !== held), 1'b1);

        // rst with load mid-run; load with en
        cyc(1, 0, 1, 9'h055);
        chk("rst_load_q", q, 9'h001);
        chk("rst_load_len", period_len, 0);
        cyc(0, 1, 1, 9'h123);
        chk("load_en_q", q, 9'h123);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] v;
            v = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 149) == 0, v);
        end

        // XNOR instance, SEED=0, lock-up state all-ones
        @(negedge clk); rst1 = 1'b1;
        @(posedge clk); #1;
        chk("xnor_reset_q", q1, 9'h000);
        chk("xnor_fb", fb1, 1'b1);
        @(negedge clk); rst1 = 1'b0; load1 = 1'b1; load_val1 = 9'h1FF;
        @(posedge clk); #1;
        chk("xnor_loaded_q", q1, 9'h1FF);
        @(negedge clk); load1 = 1'b0; en1 = 1'b1;
        @(posedge clk); #1;
        chk("xnor_lock_q", q1, 9'h000);
        chk("xnor_lock_pulse", lockup1, 1'b1);
        chk("xnor_lock_nowrap", wrap1, 1'b0);
        @(posedge clk); #1;
        chk("xnor_step_q", q1, 9'h001);
        chk("xnor_lock_once", lockup1, 1'b0);
        @(negedge clk); en1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random source, the successor to the fixed 9-bit LFSR.
- Width, tap polynomial, XOR/XNOR mode and seed are parameters.
- Adds step enable, runtime state load, lock-up detection with automatic recovery, and period measurement.
- Used as a PRBS/test-pattern generator and as a scrambler seed source.

Parameters:
- WIDTH, 9, state width in bits (2..32).
- TAPS, 9'h110, tap mask; bit i set means q[i] feeds the feedback reduction; TAPS[WIDTH-1] must be 1.
- XNOR, 0, 0 = XOR feedback (lock-up state all-zeros); 1 = XNOR feedback (lock-up state all-ones).
- SEED, 1, reset/recovery state; must not equal the lock-up state.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  advance the LFSR one step this cycle
- load  input  1  load load_val into the state this cycle
- load_val  input  WIDTH  value for load
- q  output  WIDTH  current LFSR state
- fb  output  1  combinational feedback bit computed from the current q
- wrap  output  1  registered one-cycle pulse: state has just returned to the start value
- period_len  output  WIDTH  step count of the last completed cycle
- lockup  output  1  registered one-cycle pulse: lock-up detected and recovered

Behaviour:
- Reset, synchronous on rising clk with rst=1: q=SEED, internal start=SEED, internal step counter cnt=0, period_len=0, wrap=0, lockup=0.
- Feedback:
  - fb = reduction-XOR of (q & TAPS).
  - When XNOR=1, fb is inverted.
- Step: next q = {q[WIDTH-2:0], fb}, a shift toward the MSB with fb entering bit 0.
- Priority each cycle: rst > load > en. With none asserted, all state holds.
- wrap and lockup default to 0 every cycle unless set by the rules below.
- load:
  - q=load_val, start=load_val, cnt=0; period_len is unchanged.
  - No wrap pulse; en is ignored that cycle.
  - Loading the lock-up value is permitted; recovery happens on the next en.
- en with q == lock-up state:
  - q=SEED, start=SEED, cnt=0, lockup=1 next cycle.
  - No shift and no wrap this step.
- en, normal step:
  - If next q == start: wrap=1 next cycle, period_len=cnt+1, cnt=0.
  - Otherwise: cnt=cnt+1.
- cnt never overflows: the period is at most 2^WIDTH-1 because TAPS[WIDTH-1]=1 makes the map a permutation.
- Latency: q, wrap, period_len and lockup all update on the same rising edge that commits the step. fb is combinational.
- Reset mid-run discards the count; period_len returns to 0.
- en held low: q, cnt and start are frozen; no pulses.

Test Plan:
- Reset release, default parameters, en=1 for 5 cycles -> q = 001 after reset, then 002, 004, 008, 010, 021 (hex); wrap=0, lockup=0.
- en=1 continuously for 511 steps from reset -> wrap pulses exactly once, on step 511, with q=9'h001 and period_len=511; step 1022 pulses again.
- load=1, load_val=9'h0AB, then en for 511 steps -> wrap pulses on step 511 with q=9'h0AB and period_len=511. A load mid-count restarts cnt.
- load_val=0 loaded, then en=1 -> next cycle q=9'h001 and lockup=1 for one cycle, wrap=0. Instance with XNOR=1 and SEED=0: loading 9'h1FF then en -> q=0 and lockup=1.
- en toggled 1,0,0,1 -> q advances only on en=1 cycles; held values are identical across en=0 cycles.
- rst and load asserted in the same cycle mid-run -> q=SEED, period_len=0, no pulses. load and en asserted together -> q=load_val with no step applied.
